mdio_responder: RTL
===================

// Module: mdio_responder
// PURPOSE
//  Clause-22 MDIO target (PHY side) of the MII management bus used by phy_cfg/mdio. Oversamples
//  MDC/MDIO on a fast system clock, decodes read/write frames for its PHY address, serves a small
//  R/W register bank plus read-only status reg 31 (speed/duplex). Used as a PHY model in the bench.
// PARAMETERS
//  PHY_ADDR      5'd0      PHYAD this target answers to; all other addresses are ignored
//  REG_COUNT     8         R/W registers 0..REG_COUNT-1 (2..31)
//  REG0_RESET    16'h1140  reset/soft-reset value of reg 0; regs 1..REG_COUNT-1 reset to 16'h0000
//  MIN_PREAMBLE  32        consecutive MDIO ones required before ST
// PORTS
//  clock          in   1   system clock, >= 8x MDC; MDC high and low each >= 3 clock periods
//  reset          in   1   synchronous, active-high
//  mdc_pin        in   1   MDC from station manager (asynchronous)
//  mdio_i         in   1   MDIO sampled from pad (asynchronous)
//  mdio_o         out  1   MDIO drive value; pad = mdio_oe ? mdio_o : 1'bz
//  mdio_oe        out  1   MDIO output enable
//  link_speed     in   2   reported in reg 31 bits [3:2]
//  link_duplex    in   1   reported in reg 31 bit 4
//  reg_wr_strobe  out  1   one-clock pulse per accepted write
//  reg_wr_addr    out  5   address of that write (held until next write)
//  reg_wr_data    out  16  data of that write (held until next write)
//  soft_reset     out  1   one-clock pulse when reg 0 bit 15 written as 1
// BEHAVIOUR
//  Reset: mdio_oe=0, mdio_o=1, strobes/soft_reset=0, reg_wr_addr/data=0, bank to reset values, IDLE.
//  Reset wins over any simultaneous MDC edge; reset mid-frame releases mdio_oe on the next clock.
//  mdc_pin/mdio_i: 2-FF synchronisers; MDC rise = sync'd 0->1. All sampling and state updates
//  occur on the clock after rise detection; mdio_o/oe change only in that clock (fixed latency).
//  States: IDLE (count ones; 0 clears count) -> ST when count>=MIN_PREAMBLE and a 0 is sampled;
//   ST: next bit must be 1 else IDLE; OP 2 bits: 10 read, 01 write, 00/11 -> SKIP;
//   PHYAD 5 bits MSB first, REGAD 5 bits MSB first; PHYAD != PHY_ADDR -> SKIP;
//   TA 2 bits; DATA 16 bits MSB first; then IDLE (preamble count restarts at 0).
//   SKIP: count out remaining bits to frame end, never drives, no writes, then IDLE.
//  Read: TA bit 1 undriven; after rise sampling TA bit 1 -> oe=1,o=0 and load shift register
//   (snapshot, reg 31 sampled from inputs at this clock); after each following rise present next
//   data bit, D15 first; after rise that ends D0 -> oe=0, o=1. Exactly 17 bit periods driven.
//  Write: TA must sample 1 then 0 else SKIP. After 16th data bit: register updated,
//   reg_wr_strobe pulses one clock with addr/data, same clock as bank update.
//  Map: 0..REG_COUNT-1 R/W; 31 RO {11'b0, link_duplex, link_speed, 2'b00}; others read 16'h0000,
//   writes dropped (strobe still pulses). Write to 31 dropped (strobe pulses).
//  Reg 0 bit 15 self-clearing: write with bit15=1 -> soft_reset pulse, all R/W regs reload reset
//   values in that clock (written word discarded); reg 0 bit 15 always reads 0.
//  Back-to-back frames with no gap beyond preamble are legal.
// CONFIGURATION
//  MDIO_PREAMBLE_SUPPRESS_EN defined: ST accepted after >=1 idle one (preamble suppression);
//   count reset after each frame still applies. Undefined: MIN_PREAMBLE ones strictly required;
//   frames with fewer are silently ignored (no drive, no write).
// TESTING
//  1 reset, read reg 0 (32-bit preamble, PHYAD=PHY_ADDR) -> 16'h1140; oe high for 17 bits only
//  2 write reg 4 = 16'hABCD then read reg 4 -> one strobe addr 4 data ABCD; read returns ABCD
//  3 link_speed=2'b10, link_duplex=1, read reg 31 -> 16'h0018; write reg 31 -> still 16'h0018
//  4 read with PHYAD=PHY_ADDR+1 -> mdio_oe never asserted; write mismatch -> no strobe
//  5 31-bit preamble read -> ignored (no oe) without macro; with macro 1-one preamble read works
//  6 write reg4=0x1234, write reg0=0x8000 -> soft_reset pulse; reg4 reads 0, reg0 reads 0x1140
//  7 assert reset during DATA of a read -> mdio_oe=0 next clock; next frame decodes normally

Source files
------------

// File: rtl/mdio_responder_if.sv
// rtl/mdio_responder_if.sv - MDIO management pins between station manager and PHY target
interface mdio_responder_if;
  logic mdc_pin;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (output mdc_pin, output mdio_i, input mdio_o, input mdio_oe);
  modport slave  (input mdc_pin, input mdio_i, output mdio_o, output mdio_oe);
endinterface

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause-22 MDIO PHY target with small R/W bank and status reg 31
// Optional MDIO_PREAMBLE_SUPPRESS_EN: accept ST after a single idle one.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int          REG_COUNT    = 8,
  parameter logic [15:0] REG0_RESET   = 16'h1140,
  parameter int          MIN_PREAMBLE = 32
) (
  input  logic            clock,
  input  logic            reset,
  mdio_responder_if.slave mdio,
  input  logic [1:0]      link_speed,
  input  logic            link_duplex,
  output logic            reg_wr_strobe,
  output logic [4:0]      reg_wr_addr,
  output logic [15:0]     reg_wr_data,
  output logic            soft_reset
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_MIN = 6'd1;
`else
  localparam logic [5:0] PRE_MIN = 6'(MIN_PREAMBLE);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  mdc_sync_q, mdc_sync_d;
  logic [1:0]  mdio_sync_q, mdio_sync_d;
  logic [5:0]  pre_q, pre_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] sr_q, sr_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        reg_wr_strobe_q, reg_wr_strobe_d;
  logic [4:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [15:0] reg_wr_data_q, reg_wr_data_d;
  logic        soft_reset_q, soft_reset_d;
  logic [15:0] bank_q [REG_COUNT];
  logic [15:0] bank_d [REG_COUNT];

  logic        rise, bit_in, is_read;
  logic [15:0] rd_word, wdata;

  assign rise    = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign bit_in  = mdio_sync_q[1];
  assign is_read = (op_q == 2'b10);
  assign wdata   = {sr_q[14:0], bit_in};

  always_comb begin
    rd_word = 16'h0000;
    if (addr_q == 5'd31) begin
      rd_word = {11'b0, link_duplex, link_speed, 2'b00};
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (addr_q == 5'(i)) rd_word = bank_q[i];
      end
    end
    if (addr_q == 5'd0) rd_word[15] = 1'b0;
  end

  always_comb begin
    state_d         = state_q;
    mdc_sync_d      = {mdc_sync_q[1:0], mdio.mdc_pin};
    mdio_sync_d     = {mdio_sync_q[0], mdio.mdio_i};
    pre_d           = pre_q;
    idx_d           = idx_q;
    op_d            = op_q;
    addr_d          = addr_q;
    sr_d            = sr_q;
    mdio_o_d        = mdio_o_q;
    mdio_oe_d       = mdio_oe_q;
    reg_wr_strobe_d = 1'b0;
    reg_wr_addr_d   = reg_wr_addr_q;
    reg_wr_data_d   = reg_wr_data_q;
    soft_reset_d    = 1'b0;
    bank_d          = bank_q;

    if (rise) begin
      // idx counts frame bits from the first ST bit (0) to the last data bit (31)
      if (state_q != S_IDLE) idx_d = idx_q + 5'd1;
      case (state_q)
        S_IDLE: begin
          if (bit_in) begin
            if (pre_q != 6'h3f) pre_d = pre_q + 6'd1;
          end else begin
            pre_d = 6'd0;
            if (pre_q >= PRE_MIN) begin
              state_d = S_ST;
              idx_d   = 5'd1;
            end
          end
        end
        S_ST: state_d = bit_in ? S_OP : S_IDLE;
        S_OP: begin
          op_d = {op_q[0], bit_in};
          if (idx_q == 5'd3) begin
            state_d = (op_q[0] != bit_in) ? S_PHYAD : S_SKIP;
          end
        end
        S_PHYAD: begin
          addr_d = {addr_q[3:0], bit_in};
          if (idx_q == 5'd8) begin
            state_d = ({addr_q[3:0], bit_in} == PHY_ADDR) ? S_REGAD : S_SKIP;
          end
        end
        S_REGAD: begin
          addr_d = {addr_q[3:0], bit_in};
          if (idx_q == 5'd13) state_d = S_TA;
        end
        S_TA: begin
          if (idx_q == 5'd14) begin
            if (is_read) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
              sr_d      = rd_word;
            end else if (!bit_in) begin
              state_d = S_SKIP;
            end
          end else if (is_read) begin
            mdio_o_d = sr_q[15];
            sr_d     = {sr_q[14:0], 1'b0};
            state_d  = S_DATA;
          end else begin
            state_d = bit_in ? S_SKIP : S_DATA;
          end
        end
        S_DATA: begin
          if (is_read) begin
            if (idx_q == 5'd31) begin
              mdio_oe_d = 1'b0;
              mdio_o_d  = 1'b1;
              state_d   = S_IDLE;
            end else begin
              mdio_o_d = sr_q[15];
              sr_d     = {sr_q[14:0], 1'b0};
            end
          end else begin
            sr_d = wdata;
            if (idx_q == 5'd31) begin
              state_d         = S_IDLE;
              reg_wr_strobe_d = 1'b1;
              reg_wr_addr_d   = addr_q;
              reg_wr_data_d   = wdata;
              if (addr_q == 5'd0 && wdata[15]) begin
                // soft reset reloads the whole bank; the written word is discarded
                soft_reset_d = 1'b1;
                for (int i = 0; i < REG_COUNT; i++) bank_d[i] = (i == 0) ? REG0_RESET : 16'h0000;
              end else begin
                for (int i = 0; i < REG_COUNT; i++) begin
                  if (addr_q == 5'(i) && addr_q != 5'd31) bank_d[i] = wdata;
                end
              end
            end
          end
        end
        S_SKIP: if (idx_q == 5'd31) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      mdc_sync_q      <= 3'b000;
      mdio_sync_q     <= 2'b11;
      pre_q           <= 6'd0;
      idx_q           <= 5'd0;
      op_q            <= 2'b00;
      addr_q          <= 5'd0;
      sr_q            <= 16'h0000;
      mdio_o_q        <= 1'b1;
      mdio_oe_q       <= 1'b0;
      reg_wr_strobe_q <= 1'b0;
      reg_wr_addr_q   <= 5'd0;
      reg_wr_data_q   <= 16'h0000;
      soft_reset_q    <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) bank_q[i] <= (i == 0) ? REG0_RESET : 16'h0000;
    end else begin
      state_q         <= state_d;
      mdc_sync_q      <= mdc_sync_d;
      mdio_sync_q     <= mdio_sync_d;
      pre_q           <= pre_d;
      idx_q           <= idx_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      sr_q            <= sr_d;
      mdio_o_q        <= mdio_o_d;
      mdio_oe_q       <= mdio_oe_d;
      reg_wr_strobe_q <= reg_wr_strobe_d;
      reg_wr_addr_q   <= reg_wr_addr_d;
      reg_wr_data_q   <= reg_wr_data_d;
      soft_reset_q    <= soft_reset_d;
      bank_q          <= bank_d;
    end
  end

  assign mdio.mdio_o   = mdio_o_q;
  assign mdio.mdio_oe  = mdio_oe_q;
  assign reg_wr_strobe = reg_wr_strobe_q;
  assign reg_wr_addr   = reg_wr_addr_q;
  assign reg_wr_data   = reg_wr_data_q;
  assign soft_reset    = soft_reset_q;

endmodule
